// File: rtl/skein_pkg.sv
// Shared Skein constants and the serializer state encoding.
package skein_pkg;

  localparam int STATE_W   = 1024;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = STATE_W / BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_DONE
  } ser_state_e;

endpackage

// File: rtl/output_serializer.sv
// Unloads a captured Skein state word as little-endian bytes over valid/ready,
// then pulses done_o once the final byte has been accepted.
module output_serializer #(
  parameter int STATE_W = skein_pkg::STATE_W,
  parameter int BYTE_W  = skein_pkg::BYTE_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [STATE_W-1:0] state_i,
  input  logic               ready_i,
  output logic [BYTE_W-1:0]  byte_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  import skein_pkg::ser_state_e;
  import skein_pkg::SER_IDLE;
  import skein_pkg::SER_SEND;
  import skein_pkg::SER_DONE;

  localparam int NUM_BYTES = STATE_W / BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  ser_state_e         state_q, state_d;
  logic [STATE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               handshake;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign handshake = valid_q && ready_i;

  // clear_i outranks both a pending load and a handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = SER_IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SER_IDLE: begin
          if (load_i) begin
            state_d = SER_SEND;
            shift_d = state_i;
            cnt_d   = '0;
            valid_d = 1'b1;
          end
        end
        SER_SEND: begin
          valid_d = 1'b1;
          if (handshake) begin
            shift_d = shift_q >> BYTE_W;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = SER_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        SER_DONE: begin
          state_d = SER_IDLE;
        end
        default: begin
          state_d = SER_IDLE;
        end
      endcase
    end
  end

  // The shift register is zero outside a send, so byte_o idles at zero.
  assign byte_o  = shift_q[BYTE_W-1:0];
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != SER_IDLE);

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: a vector table for the first cycles,
// directed multi-cycle corner cases, and randomized traffic against a byte-queue model.
module tb_output_serializer;

  localparam int STATE_W = 1024;
  localparam int BYTE_W  = 8;
  localparam int NB      = STATE_W / BYTE_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               load;
  logic               ready;
  logic [STATE_W-1:0] stateIn;
  logic [BYTE_W-1:0]  byteOut;
  logic               validOut;
  logic               busyOut;
  logic               doneOut;

  int checks   = 0;
  int failures = 0;

  // Reference model: the bytes still owed to the receiver, plus a done-pulse flag.
  logic [7:0] modelQ[$];
  bit         modelDone;

  typedef struct {
    bit         ld;
    bit         cl;
    bit         rd;
    logic [7:0] eByte;
    bit         eValid;
    bit         eBusy;
    bit         eDone;
  } vec_t;

  vec_t vecs[12];

  output_serializer #(.STATE_W(STATE_W), .BYTE_W(BYTE_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .load_i  (load),
    .state_i (stateIn),
    .ready_i (ready),
    .byte_o  (byteOut),
    .valid_o (validOut),
    .busy_o  (busyOut),
    .done_o  (doneOut)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [STATE_W-1:0] rampState();
    logic [STATE_W-1:0] s;
    for (int k = 0; k < NB; k++) s[8*k +: 8] = 8'(k);
    return s;
  endfunction

  function automatic logic [STATE_W-1:0] randState();
    logic [STATE_W-1:0] s;
    for (int i = 0; i < STATE_W / 32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelDone = 1'b0;
  endtask

  // Evaluates the frame rules for one clock edge using the currently driven inputs.
  task automatic modelStep();
    if (clear) begin
      modelReset();
    end else if (modelQ.size() == 0 && !modelDone && load) begin
      for (int k = 0; k < NB; k++) modelQ.push_back(stateIn[8*k +: 8]);
    end else if (modelQ.size() > 0 && ready) begin
      void'(modelQ.pop_front());
      modelDone = (modelQ.size() == 0);
    end else begin
      modelDone = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    bit         expValid;
    logic [7:0] expByte;
    expValid = (modelQ.size() > 0);
    expByte  = expValid ? modelQ[0] : 8'h00;
    checkVal({tag, ".valid"}, 32'(validOut), 32'(expValid));
    checkVal({tag, ".byte"},  32'(byteOut),  32'(expByte));
    checkVal({tag, ".busy"},  32'(busyOut),  32'(expValid || modelDone));
    checkVal({tag, ".done"},  32'(doneOut),  32'(modelDone));
  endtask

  task automatic applyStimulus(input bit ld, input bit cl, input bit rd,
                               input logic [STATE_W-1:0] st);
    load    = ld;
    clear   = cl;
    ready   = rd;
    stateIn = st;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [STATE_W-1:0] ramp;
    logic [STATE_W-1:0] other;
    logic [STATE_W-1:0] ones;
    int hs;
    int doneCnt;
    int doneAt;
    int busyLowAt;
    int restartEdge;
    bit rd;
    bit ld;
    bit pulsed;
    bit prevValid;

    ramp = rampState();
    ones = '1;

    // {load, clear, ready} driven for one cycle, then outputs after that edge.
    vecs[0]  = '{0, 0, 1, 8'h00, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h00, 1, 1, 0};
    vecs[2]  = '{0, 0, 0, 8'h00, 1, 1, 0};
    vecs[3]  = '{0, 0, 1, 8'h01, 1, 1, 0};
    vecs[4]  = '{1, 0, 1, 8'h02, 1, 1, 0};
    vecs[5]  = '{0, 0, 0, 8'h02, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 8'h03, 1, 1, 0};
    vecs[7]  = '{0, 1, 1, 8'h00, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 8'h00, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 8'h00, 1, 1, 0};
    vecs[10] = '{0, 0, 1, 8'h01, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 8'h00, 0, 0, 0};

    rst = 1'b1; clear = 1'b0; load = 1'b0; ready = 1'b0; stateIn = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset.valid", 32'(validOut), 32'd0);
    checkVal("reset.byte",  32'(byteOut),  32'd0);
    checkVal("reset.busy",  32'(busyOut),  32'd0);
    checkVal("reset.done",  32'(doneOut),  32'd0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].cl, vecs[i].rd, ramp);
      checkVal($sformatf("vec%0d.valid", i), 32'(validOut), 32'(vecs[i].eValid));
      checkVal($sformatf("vec%0d.byte", i),  32'(byteOut),  32'(vecs[i].eByte));
      checkVal($sformatf("vec%0d.busy", i),  32'(busyOut),  32'(vecs[i].eBusy));
      checkVal($sformatf("vec%0d.done", i),  32'(doneOut),  32'(vecs[i].eDone));
    end

    $display("[TB] full ramp frame, ready held high");
    doneAt = -1;
    busyLowAt = -1;
    applyStimulus(1, 0, 1, ramp);
    checkOutput("ramp");
    checkVal("ramp.first", 32'(byteOut), 32'd0);
    for (int j = 2; j <= 131; j++) begin
      applyStimulus(0, 0, 1, ramp);
      checkOutput("ramp");
      if (j <= NB) checkVal("ramp.seq", 32'(byteOut), 32'(j - 1));
      if (doneOut && doneAt < 0) doneAt = j;
      if (!busyOut && busyLowAt < 0) busyLowAt = j;
    end
    checkVal("ramp.doneCycle", 32'(doneAt), 32'd129);
    checkVal("ramp.busyLowCycle", 32'(busyLowAt), 32'd130);

    $display("[TB] ramp frame, ready toggling");
    hs = 0;
    doneCnt = 0;
    applyStimulus(1, 0, 0, ramp);
    checkOutput("toggle");
    for (int j = 0; j < 300; j++) begin
      rd = (j % 2 == 0);
      if (validOut && rd) begin
        checkVal("toggle.accepted", 32'(byteOut), 32'(hs));
        hs++;
      end
      applyStimulus(0, 0, rd, ramp);
      checkOutput("toggle");
      if (doneOut) doneCnt++;
    end
    checkVal("toggle.handshakes", 32'(hs), 32'(NB));
    checkVal("toggle.donePulses", 32'(doneCnt), 32'd1);

    $display("[TB] load during send is ignored");
    hs = 0;
    pulsed = 1'b0;
    other = randState();
    applyStimulus(1, 0, 1, ramp);
    for (int j = 0; j < 135; j++) begin
      ld = (hs == 40 && !pulsed);
      if (ld) pulsed = 1'b1;
      if (validOut) begin
        checkVal("midload.accepted", 32'(byteOut), 32'(hs));
        hs++;
      end
      applyStimulus(ld, 0, 1, ld ? other : ramp);
      checkOutput("midload");
    end
    checkVal("midload.handshakes", 32'(hs), 32'(NB));

    $display("[TB] clear together with a handshake at byte 64");
    applyStimulus(1, 0, 1, ramp);
    for (int j = 0; j < 64; j++) begin
      applyStimulus(0, 0, 1, ramp);
      checkOutput("clear");
    end
    checkVal("clear.at64", 32'(byteOut), 32'd64);
    applyStimulus(0, 1, 1, ramp);
    checkVal("clear.valid", 32'(validOut), 32'd0);
    checkVal("clear.busy",  32'(busyOut),  32'd0);
    checkVal("clear.done",  32'(doneOut),  32'd0);
    checkVal("clear.byte",  32'(byteOut),  32'd0);
    applyStimulus(0, 0, 1, ramp);
    checkVal("clear.noDone", 32'(doneOut), 32'd0);
    other = randState();
    applyStimulus(1, 0, 1, other);
    checkVal("clear.fresh0", 32'(byteOut), 32'(other[7:0]));
    for (int j = 0; j < 130; j++) begin
      applyStimulus(0, 0, 1, other);
      checkOutput("clear.fresh");
    end

    $display("[TB] asynchronous reset mid-frame");
    other = randState();
    applyStimulus(1, 0, 1, other);
    for (int j = 0; j < 50; j++) begin
      applyStimulus(0, 0, $urandom_range(0, 1) == 1, other);
      checkOutput("arst.pre");
    end
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkVal("arst.valid", 32'(validOut), 32'd0);
    checkVal("arst.byte",  32'(byteOut),  32'd0);
    checkVal("arst.busy",  32'(busyOut),  32'd0);
    checkVal("arst.done",  32'(doneOut),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    other = randState();
    applyStimulus(1, 0, 1, other);
    checkVal("arst.reload0", 32'(byteOut), 32'(other[7:0]));
    for (int j = 0; j < 130; j++) begin
      applyStimulus(0, 0, 1, other);
      checkOutput("arst.post");
    end

    $display("[TB] all-ones frames with load held high");
    restartEdge = -1;
    applyStimulus(1, 0, 1, ones);
    checkOutput("b2b");
    prevValid = validOut;
    for (int j = 2; j <= 135; j++) begin
      applyStimulus(1, 0, 1, ones);
      checkOutput("b2b");
      if (validOut && !prevValid && restartEdge < 0) begin
        restartEdge = j - 1;
        checkVal("b2b.byte0", 32'(byteOut), 32'hFF);
      end
      prevValid = validOut;
    end
    checkVal("b2b.restartEdge", 32'(restartEdge), 32'd130);
    applyStimulus(0, 1, 0, ones);
    checkOutput("b2b.clear");

    $display("[TB] randomized traffic");
    other = randState();
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 7) == 0) other = randState();
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 249) == 0,
                    $urandom_range(0, 3) != 0, other);
      checkOutput("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
